// File: rtl/demux_1to8_reg.sv
//------------------------------------------------------------------------------
// Module   : demux_1to8_reg
// Brief    : Registered 1-to-8 nibble demux with auto/explicit lane addressing
//            and frame-fill tracking.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module demux_1to8_reg #(
  parameter int WIDTH = 4,
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             addr_mode,
  input  logic [2:0]       sel,
  input  logic             clear,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [7:0]       lane_valid,
  output logic [2:0]       ptr,
  output logic             frame_done
);

  localparam logic [7:0] C_ALL_LANES = 8'hFF;

  logic [WIDTH-1:0] r_lane [0:LANES-1];
  logic [7:0]       r_lane_valid;
  logic [2:0]       r_ptr;
  logic             r_frame_done;

  logic [2:0]       w_target;
  logic [7:0]       w_valid_next;
  logic             w_complete;

  always_comb begin
    w_target     = addr_mode ? sel : r_ptr;
    w_valid_next = r_lane_valid | (8'd1 << w_target);
    w_complete   = (w_valid_next == C_ALL_LANES);
  end

  // Completion resets the tracking state but keeps the finished frame's data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) r_lane[k] <= '0;
      r_lane_valid <= 8'h00;
      r_ptr        <= 3'd0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < LANES; k++) r_lane[k] <= '0;
      r_lane_valid <= 8'h00;
      r_ptr        <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (in_valid) begin
        r_lane[w_target] <= in;
        if (w_complete) begin
          r_lane_valid <= 8'h00;
          r_ptr        <= 3'd0;
          r_frame_done <= 1'b1;
        end else begin
          r_lane_valid <= w_valid_next;
          if (!addr_mode) r_ptr <= r_ptr + 3'd1;
        end
      end
    end
  end

  assign out0       = r_lane[0];
  assign out1       = r_lane[1];
  assign out2       = r_lane[2];
  assign out3       = r_lane[3];
  assign out4       = r_lane[4];
  assign out5       = r_lane[5];
  assign out6       = r_lane[6];
  assign out7       = r_lane[7];
  assign lane_valid = r_lane_valid;
  assign ptr        = r_ptr;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire
